bpred_resolve_queue: RTL and testbench
======================================

# bpred_resolve_queue

Execute-side companion to the perceptron branch predictor. Records every prediction fetch makes in an in-order circular queue, compares each against the outcome execute resolves, and drives the predictor's update/recovery inputs (`execute_bpredictor_*`) plus the fetch redirect (`fetch_redirect`, `fetch_redirect_PC`). On a mispredict it flushes all younger in-flight records and restores the RAS index snapshot.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `RASW`, 4: RAS index snapshot width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `f_valid`  in  1  fetch issues a branch prediction record this cycle.
- `f_pc`  in  32  PC of the predicted branch.
- `f_pred_dir`  in  1  predicted direction (1 = taken).
- `f_pred_next`  in  32  PC fetch chose after this branch.
- `f_ras_index`  in  RASW  RAS index at prediction time.
- `f_ready`  out  1  queue accepts a record this cycle.
- `e_valid`  in  1  execute resolves the oldest record this cycle.
- `e_dir`  in  1  actual direction.
- `e_target`  in  32  actual taken target.
- `count`  out  log2(DEPTH)+1  occupied entries.
- `e_error`  out  1  resolve arrived with queue empty (1-cycle pulse).
- `execute_bpredictor_update`  out  1  update strobe to predictor.
- `execute_bpredictor_PC4`  out  32  stored PC + 4.
- `execute_bpredictor_target`  out  32  `e_target` of the resolved record.
- `execute_bpredictor_dir`  out  1  `e_dir` of the resolved record.
- `execute_bpredictor_miss`  out  1  record was mispredicted.
- `execute_bpredictor_recover_ras`  out  1  restore RAS index.
- `execute_bpredictor_meta`  out  RASW  stored RAS index snapshot.
- `fetch_redirect`  out  1  redirect fetch this cycle.
- `fetch_redirect_PC`  out  32  corrected next PC.

## Operation
- Storage: DEPTH × {pc[31:0], pred_dir, pred_next[31:0], ras[RASW-1:0]}; head/tail pointers wrap modulo DEPTH; `count` 0..DEPTH.
- `f_ready` = reset high & count < DEPTH & ~drop, where drop = (miss detected this cycle) | `fetch_redirect`.
- Push: `f_valid & f_ready` writes tail, tail+1. `f_valid` while not ready is silently discarded.
- Resolve: `e_valid` & count>0 pops head. actual_next = `e_dir` ? `e_target` : pc+4 (32-bit, wraps). miss = (`e_dir` ≠ pred_dir) | (actual_next ≠ pred_next).
- No miss: push and pop in same cycle leave count unchanged.
- Miss: head popped; all remaining entries and any same-cycle push discarded; count = 0, head = tail. Pushes in the following cycle (`fetch_redirect` high) also discarded.
- `e_valid` with count = 0: no pop, no update, `e_error` pulses; a same-cycle push is accepted.
- Reset low: count 0, pointers 0, every output 0 (incl. `f_ready`); entries need not be cleared. Reset during a pending redirect cancels it.

## Timing
- All outputs except `f_ready` are registered; `f_ready` is combinational from state and the current-cycle miss.
- Resolve in cycle N → in N+1: `execute_bpredictor_update`=1 for exactly one cycle with PC4/target/dir/meta; `miss`=miss; `recover_ras`=miss; `fetch_redirect`=miss with `fetch_redirect_PC`=actual_next. Data outputs hold until the next strobe; strobes are 0 otherwise.
- Back-to-back `e_valid` yields back-to-back strobes; no bubble required.
- Push visible in `count` the cycle after acceptance; accepted record resolvable from the next cycle.
- `e_error` in N+1 for empty resolve in N.

## Test plan
- Reset: hold `reset`=0 two cycles with `f_valid`=1 → all outputs 0, count 0; release → `f_ready`=1.
- Correct taken: push {pc=0x100, dir=1, next=0x140, ras=3}; resolve dir=1, target=0x140 → next cycle update=1, PC4=0x104, miss=0, redirect=0, count 0.
- Direction miss with flush: push 0x100 (dir=0, next=0x104), 0x104, 0x108; resolve dir=1, target=0x200 while pushing 0x10C → next cycle miss=1, redirect=1, redirect_PC=0x200, recover_ras=1, meta=stored ras, count 0; push during redirect cycle dropped.
- Target miss: pred dir=1, next=0x300; resolve dir=1, target=0x304 → miss=1, redirect_PC=0x304.
- Full/wrap: push DEPTH records → `f_ready`=0, extra push dropped; pop 3, push 3 across wrap → resolution order matches push order, PCs intact.
- Empty resolve with simultaneous push: count 0, `e_valid`=1, `f_valid`=1 → `e_error`=1 next cycle, no update, count 1.

Source files
------------

// File: rtl/bpred_resolve_queue.sv
// In-order record queue for the perceptron predictor: checks each prediction against
// the resolved outcome, drives predictor update/recovery and the fetch redirect.
module bpred_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int RASW  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_valid,
    input  logic [31:0]              f_pc,
    input  logic                     f_pred_dir,
    input  logic [31:0]              f_pred_next,
    input  logic [RASW-1:0]          f_ras_index,
    output logic                     f_ready,
    input  logic                     e_valid,
    input  logic                     e_dir,
    input  logic [31:0]              e_target,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     e_error,
    output logic                     execute_bpredictor_update,
    output logic [31:0]              execute_bpredictor_PC4,
    output logic [31:0]              execute_bpredictor_target,
    output logic                     execute_bpredictor_dir,
    output logic                     execute_bpredictor_miss,
    output logic                     execute_bpredictor_recover_ras,
    output logic [RASW-1:0]          execute_bpredictor_meta,
    output logic                     fetch_redirect,
    output logic [31:0]              fetch_redirect_PC
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     pc_mem   [DEPTH];
    logic            dir_mem  [DEPTH];
    logic [31:0]     next_mem [DEPTH];
    logic [RASW-1:0] ras_mem  [DEPTH];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic            pop;
    logic            push;
    logic            miss_now;
    logic [31:0]     head_pc4;
    logic [31:0]     actual_next;

    always_comb begin
        pop         = reset & e_valid & (count != '0);
        head_pc4    = pc_mem[head] + 32'd4;
        actual_next = e_dir ? e_target : head_pc4;
        miss_now    = pop & ((e_dir != dir_mem[head]) | (actual_next != next_mem[head]));
        // Fetch is on the wrong path both in the detecting cycle and the redirect cycle.
        f_ready     = reset & (count < FULL) & ~(miss_now | fetch_redirect);
        push        = f_valid & f_ready;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= f_pc;
            dir_mem[tail]  <= f_pred_dir;
            next_mem[tail] <= f_pred_next;
            ras_mem[tail]  <= f_ras_index;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head                           <= '0;
            tail                           <= '0;
            count                          <= '0;
            e_error                        <= 1'b0;
            execute_bpredictor_update      <= 1'b0;
            execute_bpredictor_PC4         <= '0;
            execute_bpredictor_target      <= '0;
            execute_bpredictor_dir         <= 1'b0;
            execute_bpredictor_miss        <= 1'b0;
            execute_bpredictor_recover_ras <= 1'b0;
            execute_bpredictor_meta        <= '0;
            fetch_redirect                 <= 1'b0;
            fetch_redirect_PC              <= '0;
        end else begin
            e_error                        <= e_valid & (count == '0);
            execute_bpredictor_update      <= pop;
            execute_bpredictor_miss        <= 1'b0;
            execute_bpredictor_recover_ras <= 1'b0;
            fetch_redirect                 <= miss_now;

            if (pop) begin
                execute_bpredictor_PC4         <= head_pc4;
                execute_bpredictor_target      <= e_target;
                execute_bpredictor_dir         <= e_dir;
                execute_bpredictor_miss        <= miss_now;
                execute_bpredictor_recover_ras <= miss_now;
                execute_bpredictor_meta        <= ras_mem[head];
            end

            if (miss_now)
                fetch_redirect_PC <= actual_next;

            // A miss squashes every younger record; push is already blocked via f_ready.
            if (miss_now) begin
                head  <= tail;
                count <= '0;
            end else begin
                if (pop)
                    head <= head + 1'b1;
                if (push)
                    tail <= tail + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Scoreboard bench for bpred_resolve_queue: a record model predicts each update/redirect.
module tb_bpred_resolve_queue;

    localparam int DEPTH = 8;
    localparam int RASW  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            f_valid = 1'b0;
    logic [31:0]     f_pc = '0;
    logic            f_pred_dir = 1'b0;
    logic [31:0]     f_pred_next = '0;
    logic [RASW-1:0] f_ras_index = '0;
    logic            f_ready;
    logic            e_valid = 1'b0;
    logic            e_dir = 1'b0;
    logic [31:0]     e_target = '0;
    logic [3:0]      count;
    logic            e_error;
    logic            execute_bpredictor_update;
    logic [31:0]     execute_bpredictor_PC4;
    logic [31:0]     execute_bpredictor_target;
    logic            execute_bpredictor_dir;
    logic            execute_bpredictor_miss;
    logic            execute_bpredictor_recover_ras;
    logic [RASW-1:0] execute_bpredictor_meta;
    logic            fetch_redirect;
    logic [31:0]     fetch_redirect_PC;

    bpred_resolve_queue #(.DEPTH(DEPTH), .RASW(RASW)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .f_valid                        (f_valid),
        .f_pc                           (f_pc),
        .f_pred_dir                     (f_pred_dir),
        .f_pred_next                    (f_pred_next),
        .f_ras_index                    (f_ras_index),
        .f_ready                        (f_ready),
        .e_valid                        (e_valid),
        .e_dir                          (e_dir),
        .e_target                       (e_target),
        .count                          (count),
        .e_error                        (e_error),
        .execute_bpredictor_update      (execute_bpredictor_update),
        .execute_bpredictor_PC4         (execute_bpredictor_PC4),
        .execute_bpredictor_target      (execute_bpredictor_target),
        .execute_bpredictor_dir         (execute_bpredictor_dir),
        .execute_bpredictor_miss        (execute_bpredictor_miss),
        .execute_bpredictor_recover_ras (execute_bpredictor_recover_ras),
        .execute_bpredictor_meta        (execute_bpredictor_meta),
        .fetch_redirect                 (fetch_redirect),
        .fetch_redirect_PC              (fetch_redirect_PC)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     pc;
        logic            dir;
        logic [31:0]     next;
        logic [RASW-1:0] ras;
    } rec_t;

    typedef struct packed {
        logic [31:0]     pc4;
        logic [31:0]     target;
        logic            dir;
        logic            miss;
        logic [RASW-1:0] meta;
        logic [31:0]     rpc;
    } exp_t;

    rec_t mq[$];
    exp_t sbq[$];
    int   compared = 0;
    int   mismatched = 0;
    logic redirect_pend = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of fetch/execute inputs, advances the model, and checks the outputs.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic pd,
                                 input logic [31:0] pn, input logic [RASW-1:0] ras,
                                 input logic ev, input logic ed, input logic [31:0] et);
        logic        miss_now = 1'b0;
        logic        exp_err = 1'b0;
        logic        ready;
        int          occ;
        rec_t        r;
        exp_t        x;
        logic [31:0] actual;

        f_valid = fv; f_pc = pc; f_pred_dir = pd; f_pred_next = pn; f_ras_index = ras;
        e_valid = ev; e_dir = ed; e_target = et;

        occ = mq.size();
        if (ev) begin
            if (occ == 0) begin
                exp_err = 1'b1;
            end else begin
                r        = mq.pop_front();
                actual   = ed ? et : r.pc + 32'd4;
                miss_now = (ed != r.dir) || (actual != r.next);
                x = '{pc4: r.pc + 32'd4, target: et, dir: ed, miss: miss_now, meta: r.ras, rpc: actual};
                sbq.push_back(x);
            end
        end
        ready = (occ < DEPTH) && !redirect_pend && !miss_now;

        #1;
        checkOutput("f_ready", {31'b0, f_ready}, {31'b0, ready});

        if (miss_now)
            mq.delete();
        else if (fv && ready)
            mq.push_back('{pc: pc, dir: pd, next: pn, ras: ras});

        @(posedge clk);
        #1;
        checkOutput("count", {28'b0, count}, mq.size());
        checkOutput("e_error", {31'b0, e_error}, {31'b0, exp_err});
        checkOutput("fetch_redirect", {31'b0, fetch_redirect}, {31'b0, miss_now});
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            checkOutput("update", {31'b0, execute_bpredictor_update}, 32'd1);
            checkOutput("PC4", execute_bpredictor_PC4, x.pc4);
            checkOutput("target", execute_bpredictor_target, x.target);
            checkOutput("dir", {31'b0, execute_bpredictor_dir}, {31'b0, x.dir});
            checkOutput("miss", {31'b0, execute_bpredictor_miss}, {31'b0, x.miss});
            checkOutput("recover_ras", {31'b0, execute_bpredictor_recover_ras}, {31'b0, x.miss});
            checkOutput("meta", {28'b0, execute_bpredictor_meta}, {28'b0, x.meta});
            if (x.miss)
                checkOutput("redirect_PC", fetch_redirect_PC, x.rpc);
        end else begin
            checkOutput("update_idle", {31'b0, execute_bpredictor_update}, 32'd0);
        end
        redirect_pend = miss_now;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pushRec(input logic [31:0] pc, input logic pd, input logic [31:0] pn,
                           input logic [RASW-1:0] ras);
        applyStimulus(1'b1, pc, pd, pn, ras, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic ed, input logic [31:0] et);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b1, ed, et);
    endtask

    initial begin
        logic [31:0] rpc;
        logic        rd;
        logic        ev;
        logic        ed;
        logic [31:0] et;

        // Reset held with fetch trying to push.
        reset = 1'b0;
        f_valid = 1'b1; f_pc = 32'h40; f_pred_dir = 1'b1; f_pred_next = 32'h80;
        e_valid = 1'b1; e_dir = 1'b1; e_target = 32'h80;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("rst_f_ready", {31'b0, f_ready}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput("rst_count", {28'b0, count}, 32'd0);
            checkOutput("rst_update", {31'b0, execute_bpredictor_update}, 32'd0);
            checkOutput("rst_redirect", {31'b0, fetch_redirect}, 32'd0);
            checkOutput("rst_e_error", {31'b0, e_error}, 32'd0);
            checkOutput("rst_PC4", execute_bpredictor_PC4, 32'd0);
            checkOutput("rst_redirect_PC", fetch_redirect_PC, 32'd0);
        end
        reset = 1'b1;
        f_valid = 1'b0; e_valid = 1'b0;
        #1;
        checkOutput("rel_f_ready", {31'b0, f_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Correctly predicted taken branch.
        pushRec(32'h100, 1'b1, 32'h140, 4'd3);
        resolve(1'b1, 32'h140);
        idle();

        // Direction miss flushes younger records, same-cycle and redirect-cycle pushes.
        pushRec(32'h100, 1'b0, 32'h104, 4'd5);
        pushRec(32'h104, 1'b0, 32'h108, 4'd6);
        pushRec(32'h108, 1'b0, 32'h10C, 4'd7);
        applyStimulus(1'b1, 32'h10C, 1'b0, 32'h110, 4'd8, 1'b1, 1'b1, 32'h200);
        pushRec(32'h200, 1'b0, 32'h204, 4'd9);
        idle();

        // Target miss.
        pushRec(32'h2F0, 1'b1, 32'h300, 4'd2);
        resolve(1'b1, 32'h304);
        idle();

        // Fill to DEPTH, overflow drop, then pop/push across the pointer wrap.
        for (int i = 0; i < DEPTH; i++)
            pushRec(32'h1000 + 32'(i * 4), 1'b0, 32'h1004 + 32'(i * 4), 4'(i));
        pushRec(32'hDEAD0, 1'b0, 32'hDEAD4, 4'hF);
        for (int i = 0; i < 3; i++)
            resolve(1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            pushRec(32'h2000 + 32'(i * 4), 1'b1, 32'h3000 + 32'(i * 16), 4'(i + 10));
        while (mq.size() > 0) begin
            rd = mq[0].dir;
            resolve(rd, rd ? mq[0].next : 32'h0);
        end

        // Empty resolve with simultaneous push.
        applyStimulus(1'b1, 32'h500, 1'b0, 32'h504, 4'd1, 1'b1, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        idle();

        // Mixed traffic, mostly correct predictions with occasional misses.
        for (int n = 0; n < 80; n++) begin
            rpc = {$urandom_range(0, 32'hFFFF), 2'b00};
            rd  = 1'($urandom_range(0, 1));
            ev  = 1'($urandom_range(0, 1));
            ed  = 1'b0;
            et  = {$urandom_range(0, 32'hFFFF), 2'b00};
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
                ed = mq[0].dir;
                if (ed)
                    et = mq[0].next;
            end else begin
                ed = 1'($urandom_range(0, 1));
            end
            applyStimulus(1'($urandom_range(0, 1)), rpc, rd,
                          rd ? {$urandom_range(0, 32'hFFFF), 2'b00} : rpc + 32'd4,
                          4'($urandom_range(0, 15)), ev, ed, et);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
